spi_byte_tx: RTL and testbench

SPI_BYTE_TX -- requirements
Module: spi_byte_tx

---
 rtl/spi_byte_tx.sv | 180 ++++++++++++++++++
 tb/tb_spi_byte_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_tx.sv
// spi_byte_tx: queued SPI mode-0 byte transmitter with D/C flag.
// A 4-entry FIFO of {dc, need_delay, byte} feeds an IDLE/LOAD/SHIFT/END
// sequencer. Bytes are shifted MSB first, and o_cs stays low across
// back-to-back bytes.
// Optional feature: define SPI_TX_DELAY_EN to compile in the HOLD state.
// In HOLD, o_cs is released for DELAY cycles after a byte that requested it.
module spi_byte_tx #(
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned DELAY   = 2_700_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_we,
  input  logic [7:0] i_byte,
  input  logic       i_dc,
  input  logic       i_need_delay,
  output logic       o_full,
  output logic       o_idle,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_cs,
  output logic       o_dc,
  output logic       o_done
);

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [31:0] DELAY_W  = 32'(DELAY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_END
`ifdef SPI_TX_DELAY_EN
    , S_HOLD
`endif
  } state_t;

  state_t      state;

  logic [9:0]  mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        push;
  logic        pop;
  logic [9:0]  head;

  logic [7:0]  div_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;

`ifdef SPI_TX_DELAY_EN
  logic        cur_nd;
  logic [31:0] hold_cnt;
`else
  logic        unused_cfg;
  assign unused_cfg = ^{head[8], DELAY_W};
`endif

  assign push   = i_we && (count != 3'd4);
  assign pop    = (state == S_LOAD);
  assign head   = mem[rd_ptr];
  assign o_full = (count == 3'd4);
  assign o_idle = (count == 3'd0) && (state == S_IDLE);

  // FIFO storage and pointers; push and pop may happen in the same cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {i_dc, i_need_delay, i_byte};
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Byte sequencer with registered SPI outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      o_cs     <= 1'b1;
      o_sclk   <= 1'b0;
      o_mosi   <= 1'b0;
      o_dc     <= 1'b0;
      o_done   <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef SPI_TX_DELAY_EN
      cur_nd   <= 1'b0;
      hold_cnt <= '0;
`endif
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (count != 3'd0) state <= S_LOAD;
        end
        S_LOAD: begin
          o_cs    <= 1'b0;
          o_dc    <= head[9];
          o_mosi  <= head[7];
          shreg   <= {head[6:0], 1'b0};
          o_sclk  <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
`ifdef SPI_TX_DELAY_EN
          cur_nd  <= head[8];
`endif
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!o_sclk) begin
              o_sclk <= 1'b1;
            end else begin
              o_sclk  <= 1'b0;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= S_END;
              end else begin
                o_mosi <= shreg[7];
                shreg  <= {shreg[6:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        S_END: begin
`ifdef SPI_TX_DELAY_EN
          if (cur_nd) begin
            o_cs     <= 1'b1;
            o_mosi   <= 1'b0;
            hold_cnt <= '0;
            state    <= S_HOLD;
          end else
`endif
          begin
            o_done <= 1'b1;
            if (count != 3'd0) begin
              state <= S_LOAD;
            end else begin
              o_cs   <= 1'b1;
              o_mosi <= 1'b0;
              state  <= S_IDLE;
            end
          end
        end
`ifdef SPI_TX_DELAY_EN
        S_HOLD: begin
          // the +1 form lets DELAY=0 end HOLD after one cycle
          if ((hold_cnt + 32'd1) >= DELAY_W) begin
            hold_cnt <= '0;
            o_done   <= 1'b1;
            state    <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_tx.sv
// tb_spi_byte_tx: directed self-checking bench for spi_byte_tx.
// u_dut runs with CLK_DIV=1 and DELAY=10; u_dut3 runs with CLK_DIV=3.
module tb_spi_byte_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, we, dc, nd;
  logic [7:0] bytei;
  logic       full, idle, sclk, mosi, cs, dco, done;

  logic       we3, dc3, nd3;
  logic [7:0] byte3;
  logic       full3, idle3, sclk3, mosi3, cs3, dco3, done3;

  spi_byte_tx #(.CLK_DIV(1), .DELAY(10)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_byte(bytei), .i_dc(dc),
    .i_need_delay(nd), .o_full(full), .o_idle(idle), .o_sclk(sclk),
    .o_mosi(mosi), .o_cs(cs), .o_dc(dco), .o_done(done)
  );

  spi_byte_tx #(.CLK_DIV(3), .DELAY(10)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_we(we3), .i_byte(byte3), .i_dc(dc3),
    .i_need_delay(nd3), .o_full(full3), .o_idle(idle3), .o_sclk(sclk3),
    .o_mosi(mosi3), .o_cs(cs3), .o_dc(dco3), .o_done(done3)
  );

  int checks = 0;
  int errors = 0;

  // Observer for u_dut: counts o_done pulses, rising o_sclk and o_cs, and logs
  // the bits captured on rising o_sclk each time a byte completes
  int unsigned done_cnt = 0;
  int unsigned rise_cnt = 0;
  int unsigned cs_rise  = 0;
  int unsigned log_idx  = 0;
  logic [7:0]  cap      = '0;
  logic [7:0]  byte_log [16];
  logic        prev_sclk = 1'b0;
  logic        prev_cs   = 1'b1;

  always @(negedge clk) begin
    prev_sclk <= sclk;
    prev_cs   <= cs;
    if (sclk === 1'b1 && prev_sclk === 1'b0) begin
      rise_cnt <= rise_cnt + 1;
      cap      <= {cap[6:0], mosi};
    end
    if (cs === 1'b1 && prev_cs === 1'b0) cs_rise <= cs_rise + 1;
    if (done === 1'b1) begin
      done_cnt                <= done_cnt + 1;
      byte_log[4'(log_idx)]   <= cap;
      log_idx                 <= log_idx + 1;
    end
  end

  int unsigned d0, r0, c0, l0;
  logic [47:0] got, expv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] b, input logic d, input logic n);
    we = 1'b1; bytei = b; dc = d; nd = n;
    tick(1);
    we = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (idle === 1'b1) break;
      tick(1);
    end
    chk("idle_wait", idle, 1);
  endtask

  task automatic snap();
    d0 = done_cnt; r0 = rise_cnt; c0 = cs_rise; l0 = log_idx;
  endtask

  function automatic logic [7:0] logb(input int unsigned n);
    return byte_log[4'(l0 + n)];
  endfunction

  initial begin
    rst = 1'b1; we = 1'b0; bytei = '0; dc = 1'b0; nd = 1'b0;
    we3 = 1'b0; byte3 = '0; dc3 = 1'b0; nd3 = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_cs", cs, 1);       chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);   chk("rst_dc", dco, 0);
    chk("rst_done", done, 0);   chk("rst_full", full, 0);
    chk("rst_idle", idle, 1);
    chk("rst3_idle", idle3, 1); chk("rst3_full", full3, 0);
    chk("rst3_mosi", mosi3, 0); chk("rst3_dc", dco3, 0);

    // Single command byte 0x2A, write at edge k
    snap();
    wr(8'h2A, 1'b0, 1'b0);
    chk("a_cs_k", cs, 1);        chk("a_idle_k", idle, 0);
    tick(1); chk("a_cs_k1", cs, 1);
    tick(1); chk("a_cs_k2", cs, 0); chk("a_mosi_b7", mosi, 0); chk("a_dc", dco, 0);
    chk("a_sclk_k2", sclk, 0);
    tick(1); chk("a_sclk_k3", sclk, 1);
    tick(15); chk("a_cs_k18", cs, 0); chk("a_done_k18", done, 0);
    tick(1); chk("a_done_k19", done, 1); chk("a_cs_k19", cs, 1);
    tick(1);
    chk("a_idle", idle, 1);      chk("a_mosi_end", mosi, 0);
    chk("a_rises", rise_cnt - r0, 8);
    chk("a_ndone", done_cnt - d0, 1);
    chk("a_byte", logb(0), 8'h2A);

    // Burst: lead byte in flight so the four queued writes fill the FIFO
    snap();
    wr(8'h55, 1'b1, 1'b0);
    tick(3);
    wr(8'h00, 1'b1, 1'b0); wr(8'hEF, 1'b1, 1'b0); wr(8'h01, 1'b1, 1'b0);
    chk("b_full3", full, 0);
    wr(8'h3F, 1'b1, 1'b0);
    chk("b_full4", full, 1);
    wr(8'hAA, 1'b1, 1'b0);
    chk("b_full5", full, 1);     chk("b_dc", dco, 1);  chk("b_cs", cs, 0);
    wait_idle(300);
    tick(1);
    chk("b_ndone", done_cnt - d0, 5);
    chk("b_csrise", cs_rise - c0, 1);
    chk("b_log0", logb(0), 8'h55); chk("b_log1", logb(1), 8'h00);
    chk("b_log2", logb(2), 8'hEF); chk("b_log3", logb(3), 8'h01);
    chk("b_log4", logb(4), 8'h3F);
    chk("b_dc_end", dco, 1);

    // CLK_DIV=3: 48 SHIFT cycles of 3-low/3-high phases
    we3 = 1'b1; byte3 = 8'hA5;
    tick(1);
    we3 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (cs3 === 1'b0) break;
      tick(1);
    end
    chk("c_cs_low", cs3, 0);
    for (int j = 0; j < 48; j++) begin
      got[j]  = sclk3;
      expv[j] = ((j / 3) % 2) == 1;
      tick(1);
    end
    chk("c_sclk_pattern", got, expv);
    chk("c_end_cs", cs3, 0);     chk("c_end_done", done3, 0);
    tick(1);
    chk("c_done", done3, 1);     chk("c_cs_high", cs3, 1);

    // need_delay on the first of two bytes
    tick(2);
    snap();
    wr(8'h01, 1'b0, 1'b1);
    wr(8'h11, 1'b0, 1'b0);
`ifdef SPI_TX_DELAY_EN
    tick(18); chk("d_hold_cs", cs, 1); chk("d_hold_done", done, 0);
    tick(9);  chk("d_done_early", done, 0); chk("d_cs_w28", cs, 1);
    tick(1);  chk("d_done", done, 1);  chk("d_cs_w29", cs, 1);
    tick(1);  chk("d_cs_w30", cs, 1);
    tick(1);  chk("d_cs_w31", cs, 0);  chk("d_mosi_b7", mosi, 0);
    wait_idle(100);
    tick(1);
    chk("d_csrise", cs_rise - c0, 2);
`else
    tick(18); chk("d_done", done, 1);  chk("d_cs_burst", cs, 0);
    tick(1);  chk("d_cs_next", cs, 0);
    wait_idle(100);
    tick(1);
    chk("d_csrise", cs_rise - c0, 1);
`endif
    chk("d_ndone", done_cnt - d0, 2);
    chk("d_log0", logb(0), 8'h01);
    chk("d_log1", logb(1), 8'h11);

    // Reset after the 4th rising o_sclk with two entries still queued
    snap();
    wr(8'hC3, 1'b0, 1'b0); wr(8'h3C, 1'b0, 1'b0); wr(8'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (rise_cnt - r0 >= 4) break;
      tick(1);
    end
    chk("e_rises4", (rise_cnt - r0 >= 4), 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("e_cs", cs, 1);   chk("e_sclk", sclk, 0); chk("e_idle", idle, 1);
    chk("e_mosi", mosi, 0); chk("e_full", full, 0);
    d0 = done_cnt;
    tick(60);
    chk("e_nodone", done_cnt - d0, 0);
    chk("e_idle_later", idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
